alu_seg_display: RTL and testbench

Downstream display stage for `ALU_Top`. It captures the unsigned 9-bit `answer` whenever it changes and converts it to three BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed 4-digit common-anode seven-segment display. It sits between `ALU_Top.answer` and the board display pins.

---
 rtl/alu_seg_display.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seg_display.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seg_display.sv
// alu_seg_display: display stage behind ALU_Top. It captures the unsigned
// ALU result whenever it changes and converts it to three BCD digits with a
// sequential double-dabble engine. It then scans the digits onto a 4-digit
// common-anode seven-segment display.
//
// Parameters:
//   NUM_WIDTH   - ALU operand width; answer is NUM_WIDTH+1 bits
//   REFRESH_DIV - clk cycles each digit stays enabled (>= 2)
//
// Ports:
//   clk    - single rising-edge clock
//   reset  - asynchronous, active-high reset
//   answer - unsigned ALU result to display
//   an     - digit anode enables, active-low, an[0] = rightmost digit
//   seg    - segment cathodes, active-low, {g,f,e,d,c,b,a}
//   dp     - decimal point, active-low, always off
//   busy   - high while a conversion is in progress (registered)
//
// Build option:
//   BLANK_LEADING_ZERO_EN - when defined, leading zeros on the hundreds and
//                           tens digits are suppressed ("  7" instead of "007").

module alu_seg_display #(
    parameter int unsigned NUM_WIDTH   = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WIDTH:0]   answer,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 busy
);

    localparam int unsigned ANS_W  = NUM_WIDTH + 1;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ANS_W-1:0]    captured;
    logic [ANS_W-1:0]    shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [ITER_W-1:0]   iter;
    logic [3:0]          disp2;
    logic [3:0]          disp1;
    logic [3:0]          disp0;

    logic [CNT_W-1:0]    refresh_cnt;
    logic [1:0]          idx;

    logic [3:0]          sel_digit;
    logic                sel_blank;
    logic [6:0]          seg_next;

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b1111111;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Converter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (answer != captured) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                // iter counts completed shifts; the NUM_WIDTH-th cycle is the last.
                if (iter == ITER_W'(NUM_WIDTH)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and displayed digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured <= '0;
            shreg    <= '0;
            bcd      <= '0;
            iter     <= '0;
            disp2    <= '0;
            disp1    <= '0;
            disp0    <= '0;
            busy     <= 1'b0;
        end else begin
            // busy trails the state by one edge so it covers E+1..E+10.
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (answer != captured) begin
                        captured <= answer;
                        shreg    <= answer;
                        bcd      <= '0;
                        iter     <= '0;
                    end
                end
                CONV: begin
                    bcd   <= {bcd_adj[BCD_W-2:0], shreg[ANS_W-1]};
                    shreg <= {shreg[ANS_W-2:0], 1'b0};
                    iter  <= iter + ITER_W'(1);
                end
                LOAD: begin
                    disp2 <= bcd[11:8];
                    disp1 <= bcd[7:4];
                    disp0 <= bcd[3:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Refresh divider; idx advances once per REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end
    end

    // Select the digit under scan; position 3 is always blank.
    always_comb begin
        sel_digit = disp0;
        sel_blank = 1'b0;
        case (idx)
            2'd0: begin
                sel_digit = disp0;
            end
            2'd1: begin
                sel_digit = disp1;
`ifdef BLANK_LEADING_ZERO_EN
                sel_blank = (disp2 == 4'd0) && (disp1 == 4'd0);
`endif
            end
            2'd2: begin
                sel_digit = disp2;
`ifdef BLANK_LEADING_ZERO_EN
                sel_blank = (disp2 == 4'd0);
`endif
            end
            default: begin
                sel_blank = 1'b1;
            end
        endcase
        seg_next = sel_blank ? 7'b1111111 : seg_decode(sel_digit);
    end

    // Registered display drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_alu_seg_display.sv
// Self-checking bench for alu_seg_display with REFRESH_DIV = 4. A behavioural
// model (decimal arithmetic plus a conversion countdown) predicts an/seg/busy/dp
// every cycle; directed scenarios add literal checks, then random answers follow.

module tb_alu_seg_display;

    localparam int unsigned NW  = 8;
    localparam int unsigned DIV = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [NW:0]  answer = '0;
    logic [3:0]   an;
    logic [6:0]   seg;
    logic         dp;
    logic         busy;

    int total = 0;
    int bad   = 0;

    alu_seg_display #(
        .NUM_WIDTH   (NW),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .answer (answer),
        .an     (an),
        .seg    (seg),
        .dp     (dp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected pattern at scan position pos for decimal value v.
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        if (pos == 3) return 7'b1111111;
`ifdef BLANK_LEADING_ZERO_EN
        if (pos == 2 && v < 100) return 7'b1111111;
        if (pos == 1 && v < 10)  return 7'b1111111;
`endif
        case (pos)
            0: return digit_seg(v % 10);
            1: return digit_seg((v / 10) % 10);
            default: return digit_seg((v / 100) % 10);
        endcase
    endfunction

    // Behavioural model: value shown, captured value, cycles left in conversion.
    logic [3:0] e_an   = 4'hF;
    logic [6:0] e_seg  = 7'h7F;
    logic       e_busy = 1'b0;
    int m_cap  = 0;
    int m_left = 0;
    int m_disp = 0;
    int m_scan = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            e_an   = 4'hF;
            e_seg  = 7'h7F;
            e_busy = 1'b0;
            m_cap  = 0;
            m_left = 0;
            m_disp = 0;
            m_scan = 0;
        end else begin
            int pos;
            pos    = (m_scan / DIV) % 4;
            e_an   = 4'(~(4'b0001 << pos));
            e_seg  = exp_seg(m_disp, pos);
            e_busy = (m_left != 0);
            if (m_left == 0) begin
                if (int'(answer) != m_cap) begin
                    m_cap  = int'(answer);
                    m_left = 10;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_disp = m_cap;
            end
            m_scan++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("an",   int'(an),   int'(e_an));
        check("seg",  int'(seg),  int'(e_seg));
        check("busy", int'(busy), int'(e_busy));
        check("dp",   int'(dp),   1);
    end

    // Wait (bounded) until digit pos is enabled, then check its pattern.
    task automatic check_digit(input int pos, input logic [6:0] exp);
        logic [3:0] want;
        int k;
        want = 4'(~(4'b0001 << pos));
        k = 0;
        while (an != want && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (an != want) check($sformatf("digit%0d_timeout", pos), int'(an), int'(want));
        else check($sformatf("digit%0d", pos), int'(seg), int'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12 reset = 1'b0;
        @(negedge clk);
        check("first_an",   int'(an),   4'b1110);
        check("first_seg",  int'(seg),  7'b1000000);
        check("first_busy", int'(busy), 0);
        repeat (20) @(negedge clk);

        // 12: busy for exactly 10 cycles, then "012".
        answer = 9'd12;
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("busy_len", n, 10);
        check_digit(0, 7'b0100100);
        check_digit(1, 7'b1111001);
`ifdef BLANK_LEADING_ZERO_EN
        check_digit(2, 7'b1111111);
`else
        check_digit(2, 7'b1000000);
`endif

        // 511 -> 5/1/1.
        answer = 9'd511;
        repeat (12) @(negedge clk);
        check_digit(2, 7'b0010010);
        check_digit(1, 7'b1111001);
        check_digit(0, 7'b1111001);

        // 12 then 200 three cycles into the conversion.
        answer = 9'd12;
        repeat (3) @(negedge clk);
        answer = 9'd200;
        repeat (9) @(negedge clk);
        check("gap_busy", int'(busy), 0);
        @(negedge clk);
        check("second_busy", int'(busy), 1);
        repeat (10) @(negedge clk);
        check_digit(2, 7'b0100100);
        check_digit(1, 7'b1000000);
        check_digit(0, 7'b1000000);

        // Reset pulse in the middle of converting 99.
        answer = 9'd99;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_an",   int'(an),   4'b1111);
        check("rst_seg",  int'(seg),  7'b1111111);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (13) @(negedge clk);
        check_digit(0, 7'b0010000);
        check_digit(1, 7'b0010000);
`ifdef BLANK_LEADING_ZERO_EN
        check_digit(2, 7'b1111111);
`else
        check_digit(2, 7'b1000000);
`endif

        // 10 -> digits 0/1, digit 3 blank.
        answer = 9'd10;
        repeat (13) @(negedge clk);
        check_digit(0, 7'b1000000);
        check_digit(1, 7'b1111001);
        check_digit(3, 7'b1111111);

        // Random answers with random hold times, some shorter than a conversion.
        for (int i = 0; i < 60; i++) begin
            answer = 9'($urandom_range(0, 511));
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
